// File: rtl/crc16_checker.sv
// crc16_checker
// Receives a framed byte stream (payload, then CRC high byte, then CRC low byte), checks
// the CRC-16 (poly 0x8005, init 0, MSB first, no reflection, no final XOR) and forwards
// the payload through a 2-byte delay line so the CRC bytes are never forwarded.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset
//   load       in   frame start pulse; restarts any frame in progress
//   din_valid  in   din qualifier
//   din[7:0]   in   received byte
//   d_last     in   final byte of frame (with din_valid)
//   dout[7:0]  out  forwarded payload byte
//   dout_valid out  dout qualifier
//   done       out  one-cycle end-of-frame pulse
//   crc_ok     out  frame passed (held until next load/reset)
//   crc_err    out  frame failed (held until next load/reset)
//   len_err    out  frame too short or too long (held until next load/reset)
//   byte_cnt   out  forwarded payload bytes, saturating at MAX_LEN
//   busy       out  not idle
module crc16_checker #(
    parameter int unsigned MAX_LEN = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        din_valid,
    input  logic [7:0]  din,
    input  logic        d_last,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        done,
    output logic        crc_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic [15:0] byte_cnt,
    output logic        busy
);

    // Accepted-byte counter must reach MAX_LEN+3 without wrapping.
    localparam int unsigned     CNT_W   = $clog2(MAX_LEN + 4) + 1;
    localparam logic [CNT_W-1:0] OVF_CNT = CNT_W'(MAX_LEN + 3);
    localparam logic [15:0]     CNT_MAX = 16'(MAX_LEN);

    typedef enum logic [1:0] {StIdle, StRecv, StCheck, StDrain} state_e;

    state_e           r_state;
    logic [15:0]      r_crc;
    logic [CNT_W-1:0] r_acc;
    logic [7:0]       r_d0;
    logic [7:0]       r_d1;
    logic [7:0]       r_dout;
    logic             r_dout_valid;
    logic             r_done;
    logic             r_ok;
    logic             r_err;
    logic             r_len;
    logic [15:0]      r_byte_cnt;

    logic [15:0]      w_crc_next;
    logic [CNT_W-1:0] w_acc_next;
    logic             w_fwd;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h8005;
        end
        return r;
    endfunction

    assign w_crc_next = crc_byte(r_crc, din);
    assign w_acc_next = r_acc + CNT_W'(1);
    // Two bytes must be held back before anything can leave the delay line.
    assign w_fwd      = (r_acc >= CNT_W'(2)) && (r_byte_cnt < CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_crc        <= 16'h0000;
            r_acc        <= '0;
            r_d0         <= 8'h00;
            r_d1         <= 8'h00;
            r_dout       <= 8'h00;
            r_dout_valid <= 1'b0;
            r_done       <= 1'b0;
            r_ok         <= 1'b0;
            r_err        <= 1'b0;
            r_len        <= 1'b0;
            r_byte_cnt   <= 16'h0000;
        end else begin
            r_dout_valid <= 1'b0;
            r_done       <= 1'b0;
            if (load) begin
                // load beats din_valid; any partial frame is dropped silently.
                r_state    <= StRecv;
                r_crc      <= 16'h0000;
                r_acc      <= '0;
                r_d0       <= 8'h00;
                r_d1       <= 8'h00;
                r_ok       <= 1'b0;
                r_err      <= 1'b0;
                r_len      <= 1'b0;
                r_byte_cnt <= 16'h0000;
            end else begin
                case (r_state)
                    StIdle: r_state <= StIdle;
                    StRecv: begin
                        if (din_valid) begin
                            r_crc <= w_crc_next;
                            r_acc <= w_acc_next;
                            r_d0  <= din;
                            r_d1  <= r_d0;
                            if (w_fwd) begin
                                r_dout       <= r_d1;
                                r_dout_valid <= 1'b1;
                                r_byte_cnt   <= r_byte_cnt + 16'd1;
                            end
                            if (d_last) begin
                                // Status appears together with done in the CHECK cycle.
                                r_state <= StCheck;
                                r_done  <= 1'b1;
                                if (w_acc_next < CNT_W'(3)) begin
                                    r_len <= 1'b1;
                                    r_err <= 1'b1;
                                end else if (w_crc_next == 16'h0000) begin
                                    r_ok  <= 1'b1;
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end else if (w_acc_next == OVF_CNT) begin
                                r_state <= StDrain;
                                r_done  <= 1'b1;
                                r_len   <= 1'b1;
                                r_err   <= 1'b1;
                            end
                        end
                    end
                    StCheck: r_state <= StIdle;
                    StDrain: begin
                        if (din_valid && d_last) r_state <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign done       = r_done;
    assign crc_ok     = r_ok;
    assign crc_err    = r_err;
    assign len_err    = r_len;
    assign byte_cnt   = r_byte_cnt;
    assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_crc16_checker.sv
// Directed bench for crc16_checker: default instance plus a MAX_LEN=4 instance sharing stimulus.
module tb_crc16_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        din_valid;
    logic [7:0]  din;
    logic        d_last;

    logic [7:0]  dout,       dout_s;
    logic        dout_valid, dout_valid_s;
    logic        done,       done_s;
    logic        crc_ok,     crc_ok_s;
    logic        crc_err,    crc_err_s;
    logic        len_err,    len_err_s;
    logic [15:0] byte_cnt,   byte_cnt_s;
    logic        busy,       busy_s;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int done1 = 0;
    int done2 = 0;

    logic [7:0] pay [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    crc16_checker u_dut (
        .clk(clk), .rst(rst), .load(load), .din_valid(din_valid), .din(din), .d_last(d_last),
        .dout(dout), .dout_valid(dout_valid), .done(done), .crc_ok(crc_ok), .crc_err(crc_err),
        .len_err(len_err), .byte_cnt(byte_cnt), .busy(busy)
    );

    crc16_checker #(.MAX_LEN(4)) u_dut_s (
        .clk(clk), .rst(rst), .load(load), .din_valid(din_valid), .din(din), .d_last(d_last),
        .dout(dout_s), .dout_valid(dout_valid_s), .done(done_s), .crc_ok(crc_ok_s),
        .crc_err(crc_err_s), .len_err(len_err_s), .byte_cnt(byte_cnt_s), .busy(busy_s)
    );

    always #5 clk = ~clk;

    // Record forwarded bytes and done pulses away from the active edge.
    always @(negedge clk) begin
        if (dout_valid)   q1.push_back(dout);
        if (dout_valid_s) q2.push_back(dout_s);
        if (done)   done1++;
        if (done_s) done2++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge after the byte was accepted.
    task automatic send(input logic [7:0] d, input logic last);
        din_valid = 1'b1;
        din       = d;
        d_last    = last;
        @(negedge clk);
        din_valid = 1'b0;
        d_last    = 1'b0;
    endtask

    task automatic do_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] crc_lo, input bit gaps);
        for (int i = 0; i < 9; i++) begin
            send(pay[i], 1'b0);
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        send(8'hFE, 1'b0);
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        send(crc_lo, 1'b1);
    endtask

    task automatic chk_payload(input string tag, input int base);
        chk({tag, "_count"}, 32'(q1.size() - base), 32'd9);
        if (q1.size() >= base + 9) begin
            for (int i = 0; i < 9; i++) chk({tag, "_byte"}, 32'(q1[base + i]), 32'(pay[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int d0;
        rst = 1'b0; load = 1'b0; din_valid = 1'b0; din = 8'h00; d_last = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_dout",       32'(dout),       32'h0);
        chk("rst_dout_valid", 32'(dout_valid), 32'h0);
        chk("rst_done",       32'(done),       32'h0);
        chk("rst_crc_ok",     32'(crc_ok),     32'h0);
        chk("rst_crc_err",    32'(crc_err),    32'h0);
        chk("rst_len_err",    32'(len_err),    32'h0);
        chk("rst_byte_cnt",   32'(byte_cnt),   32'h0);
        chk("rst_busy",       32'(busy),       32'h0);
        chk("rst_busy_s",     32'(busy_s),     32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Good frame with latency checks
        do_load();
        chk("load_busy", 32'(busy), 32'h1);
        base = q1.size(); d0 = done1;
        send(8'h31, 1'b0);
        send(8'h32, 1'b0);
        chk("lat_no_fwd", 32'(dout_valid), 32'h0);
        send(8'h33, 1'b0);
        chk("lat_first_valid", 32'(dout_valid), 32'h1);
        chk("lat_first_byte",  32'(dout),       32'h31);
        for (int i = 3; i < 9; i++) send(pay[i], 1'b0);
        send(8'hFE, 1'b0);
        send(8'hE8, 1'b1);
        chk("good_done",     32'(done),     32'h1);
        chk("good_crc_ok",   32'(crc_ok),   32'h1);
        chk("good_crc_err",  32'(crc_err),  32'h0);
        chk("good_len_err",  32'(len_err),  32'h0);
        chk("good_byte_cnt", 32'(byte_cnt), 32'd9);
        chk("good_last_fwd", 32'(dout),     32'h39);
        @(negedge clk);
        chk("good_done_drop", 32'(done),   32'h0);
        chk("good_idle",      32'(busy),   32'h0);
        chk("good_ok_held",   32'(crc_ok), 32'h1);
        chk("good_done_cnt",  32'(done1 - d0), 32'd1);
        chk_payload("good", base);

        // Corrupted CRC low byte
        do_load();
        base = q1.size();
        send_frame(8'hE9, 1'b0);
        chk("bad_crc_err", 32'(crc_err), 32'h1);
        chk("bad_crc_ok",  32'(crc_ok),  32'h0);
        chk("bad_len_err", 32'(len_err), 32'h0);
        @(negedge clk);
        chk_payload("bad", base);

        // Too-short frame
        do_load();
        base = q1.size();
        send(8'h00, 1'b0);
        send(8'h00, 1'b1);
        chk("short_done",     32'(done),     32'h1);
        chk("short_len_err",  32'(len_err),  32'h1);
        chk("short_crc_err",  32'(crc_err),  32'h1);
        chk("short_crc_ok",   32'(crc_ok),   32'h0);
        chk("short_byte_cnt", 32'(byte_cnt), 32'h0);
        @(negedge clk);
        chk("short_no_fwd", 32'(q1.size() - base), 32'd0);

        // Good frame with random din_valid gaps
        do_load();
        base = q1.size();
        send_frame(8'hE8, 1'b1);
        chk("gap_crc_ok", 32'(crc_ok), 32'h1);
        @(negedge clk);
        chk_payload("gap", base);

        // Restart mid-frame, with din_valid alongside load
        do_load();
        repeat (4) send(8'hAA, 1'b0);
        d0 = done1;
        load = 1'b1; din_valid = 1'b1; din = 8'h55;
        @(negedge clk);
        load = 1'b0; din_valid = 1'b0;
        chk("restart_cnt_clr", 32'(byte_cnt), 32'h0);
        base = q1.size();
        send_frame(8'hE8, 1'b0);
        chk("restart_crc_ok",   32'(crc_ok),   32'h1);
        chk("restart_byte_cnt", 32'(byte_cnt), 32'd9);
        @(negedge clk);
        chk("restart_done_cnt", 32'(done1 - d0), 32'd1);
        chk_payload("restart", base);

        // Overflow on the MAX_LEN=4 instance
        do_load();
        base = q2.size(); d0 = done2;
        for (int i = 1; i <= 10; i++) begin
            send(8'(i), (i == 10) ? 1'b1 : 1'b0);
            if (i == 7) begin
                chk("ovf_done",     32'(done_s),     32'h1);
                chk("ovf_len_err",  32'(len_err_s),  32'h1);
                chk("ovf_crc_err",  32'(crc_err_s),  32'h1);
                chk("ovf_crc_ok",   32'(crc_ok_s),   32'h0);
                chk("ovf_byte_cnt", 32'(byte_cnt_s), 32'd4);
            end
            if (i == 8) chk("ovf_done_drop", 32'(done_s), 32'h0);
            if (i == 9) chk("ovf_drain_busy", 32'(busy_s), 32'h1);
        end
        chk("ovf_idle",      32'(busy_s),    32'h0);
        chk("ovf_len_held",  32'(len_err_s), 32'h1);
        @(negedge clk);
        chk("ovf_done_cnt",  32'(done2 - d0), 32'd1);
        chk("ovf_fwd_count", 32'(q2.size() - base), 32'd4);
        if (q2.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) chk("ovf_fwd_byte", 32'(q2[base + i]), 32'(i + 1));
        end

        // Reset mid-frame, reset beating load
        do_load();
        d0 = done1;
        for (int i = 0; i < 5; i++) send(pay[i], 1'b0);
        rst = 1'b0; load = 1'b1;
        @(negedge clk);
        rst = 1'b1; load = 1'b0;
        chk("abort_busy",     32'(busy),     32'h0);
        chk("abort_byte_cnt", 32'(byte_cnt), 32'h0);
        chk("abort_dout",     32'(dout),     32'h0);
        @(negedge clk);
        chk("abort_no_done",  32'(done1 - d0), 32'd0);
        do_load();
        send_frame(8'hE8, 1'b0);
        chk("after_abort_ok",  32'(crc_ok),   32'h1);
        chk("after_abort_cnt", 32'(byte_cnt), 32'd9);
        @(negedge clk);
        chk("after_abort_done", 32'(done1 - d0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/crc16_checker.md
CRC16_CHECKER -- requirements
Module: crc16_checker

Interface
REQ-001 SHALL have parameter MAX_LEN, default 4096, the maximum payload bytes per frame, excluding the 2 CRC bytes.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: one clock; reset is synchronous and active-low.
REQ-004 SHALL have port load, input, 1, frame start pulse.
REQ-005 SHALL have port din_valid, input, 1, din qualifier.
REQ-006 SHALL have port din, input, 8, received byte (payload followed by CRC high byte, then CRC low byte).
REQ-007 SHALL have port d_last, input, 1, marks the final byte of a frame; meaningful only with din_valid.
REQ-008 SHALL have port dout, output, 8, forwarded payload byte.
REQ-009 SHALL have port dout_valid, output, 1, dout qualifier.
REQ-010 SHALL have port done, output, 1, one-cycle end-of-frame pulse.
REQ-011 SHALL have ports crc_ok / crc_err / len_err, outputs, 1 each, frame status.
REQ-012 SHALL have port byte_cnt, output, 16, payload byte count of the current or last frame.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL use CRC-16 with polynomial x^16+x^15+x^2+1 (0x8005), init 0x0000, no reflection, no final XOR, and process din[7] first, 8 bits per cycle.
REQ-015 SHALL update the running CRC register in the same clock edge that accepts each byte, over all bytes including the 2 CRC bytes; a correct frame leaves residue 0x0000.
REQ-016 SHALL implement FSM states IDLE, RECV, CHECK and DRAIN.
REQ-017 IDLE: inputs din_valid and d_last SHALL be ignored; on load, the block SHALL clear the CRC, byte_cnt, the delay line and all status flags, then go to RECV.
REQ-018 RECV: each din_valid cycle SHALL accept one byte; on din_valid with d_last the block SHALL go to CHECK.
REQ-019 CHECK, one cycle: done SHALL be 1; len_err SHALL be 1 if the accepted byte total is below 3; crc_ok SHALL be 1 if residue is 0 and len_err is 0; otherwise crc_err SHALL be 1; the next state SHALL be IDLE.
REQ-020 The flags crc_ok, crc_err and len_err SHALL hold their values until the next load or reset, and exactly one of crc_ok and crc_err SHALL be set after done.
REQ-021 Payload forwarding SHALL use a 2-byte delay line: byte k is output on dout with dout_valid=1 in the cycle after byte k+2 is accepted, so the 2 CRC bytes are never forwarded.
REQ-022 byte_cnt SHALL increment by 1 per forwarded byte, saturating at MAX_LEN.
REQ-023 If MAX_LEN+3 bytes are accepted without d_last, the block SHALL pulse done, set len_err=1 and crc_err=1, stop forwarding, and go to DRAIN.
REQ-024 DRAIN: the block SHALL discard bytes until din_valid with d_last, then go to IDLE with no second done pulse.
REQ-025 A load asserted in RECV or DRAIN SHALL restart the frame as from IDLE, with the partial frame discarded and no done pulse.
REQ-026 When load and din_valid are asserted in the same cycle, load SHALL win and din SHALL be ignored.
REQ-027 Gaps in din_valid SHALL stall the block only; neither CRC state nor latency shall change.

Reset
REQ-028 While rst=0 at a clock edge, the block SHALL enter IDLE, set the CRC to 0x0000, and clear the delay line, byte_cnt=0, dout=0x00, and all outputs to 0 (dout_valid, done, crc_ok, crc_err, len_err, busy).
REQ-029 Reset asserted mid-frame SHALL abort the frame with no done pulse, and reset SHALL take priority over load.

Verification
REQ-030 Scenario: load, then "123456789" (0x31..0x39), then 0xFE, 0xE8 (last) -> dout 0x31..0x39 in order, done pulse, crc_ok=1, byte_cnt=9.
REQ-031 Scenario: same frame with last byte 0xE9 -> crc_err=1, crc_ok=0, len_err=0, and 9 payload bytes still forwarded.
REQ-032 Scenario: frame 0x00, 0x00 (last) -> len_err=1, crc_err=1, no dout_valid, byte_cnt=0.
REQ-033 Scenario: random din_valid gaps on the REQ-030 frame -> identical dout sequence and crc_ok=1.
REQ-034 Scenario: MAX_LEN=4, 10 bytes sent, last on the 10th -> done after the 7th byte with len_err=1, crc_err=1, 4 bytes forwarded, busy until the 10th byte, then IDLE.
REQ-035 Scenario: rst=0 after 5 payload bytes, then a new load and the REQ-030 frame -> no done for the aborted frame, and the second frame reports crc_ok=1, byte_cnt=9.
